// File: rtl/demux_pkg.sv
// Shared helpers for the wide-to-narrow serializer family.
//   clog2       - index width for a count of items (minimum 1 bit)
//   num_slices  - slices per word for a given input/output width
//   cfg_ok      - legal geometry: whole number of slices, at least two
//   R, IDX_W    - geometry of the default 32-bit to 8-bit configuration
package demux_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int unsigned num_slices(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  function automatic bit cfg_ok(input int unsigned in_w, input int unsigned out_w);
    return (out_w != 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
  endfunction

  localparam int unsigned DEF_IN_W  = 32;
  localparam int unsigned DEF_OUT_W = 8;
  localparam int unsigned R         = num_slices(DEF_IN_W, DEF_OUT_W);
  localparam int unsigned IDX_W     = clog2(R);

endpackage

// File: rtl/slice_sel.sv
// Combinational slice extraction from a wide word.
//   word  - IN_W-bit source word
//   idx   - slice number, 0 .. IN_W/OUT_W-1
//   slice - OUT_W-bit slice; slice 0 is the top slice when MSB_FIRST, else the bottom one
module slice_sel
  import demux_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned NS       = num_slices(IN_W, OUT_W),
  localparam int unsigned IW       = clog2(NS)
) (
  input  logic [IN_W-1:0]  word,
  input  logic [IW-1:0]    idx,
  output logic [OUT_W-1:0] slice
);

  // Explicit compare per slice keeps out-of-range idx harmless for non-power-of-2 counts.
  always_comb begin
    slice = '0;
    for (int k = 0; k < NS; k++) begin
      if (idx == IW'(k)) begin
        if (MSB_FIRST) slice = word[IN_W - 1 - k * OUT_W -: OUT_W];
        else           slice = word[k * OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/demux_wide_narrow.sv
// Wide-to-narrow word serializer with a two-entry (active + pending) buffer.
//   clk_4f     - serial-side clock
//   reset      - synchronous, active-low
//   data_in    - IN_W-bit word, taken when valid_in & ready_out
//   valid_in   - data_in valid
//   ready_out  - a word can be accepted this cycle (pending slot empty)
//   data_out   - current OUT_W-bit slice, registered
//   valid_out  - data_out valid, registered
//   first_out  - data_out is slice 0 of its word
//   last_out   - data_out is the final slice of its word
module demux_wide_narrow
  import demux_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic             first_out,
  output logic             last_out
);

  localparam int unsigned NS = num_slices(IN_W, OUT_W);
  localparam int unsigned IW = clog2(NS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  if (!cfg_ok(IN_W, OUT_W)) begin : g_bad_cfg
    $error("demux_wide_narrow: IN_W must be a multiple of OUT_W with at least two slices");
  end

  logic [IN_W-1:0]  cur, pend;
  logic             cur_v, pend_v;
  logic [IW-1:0]    idx;
  logic [OUT_W-1:0] cur_slice;
  logic             accept;

  // Depends on state only, so there is no combinational path from valid_in.
  assign ready_out = !pend_v;
  assign accept    = valid_in & ready_out;

  slice_sel #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_slice_sel (
    .word  (cur),
    .idx   (idx),
    .slice (cur_slice)
  );

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      cur       <= '0;
      pend      <= '0;
      cur_v     <= 1'b0;
      pend_v    <= 1'b0;
      idx       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (cur_v) begin
      data_out  <= cur_slice;
      valid_out <= 1'b1;
      first_out <= (idx == '0);
      last_out  <= (idx == LAST_IDX);
      if (idx != LAST_IDX) begin
        idx <= idx + IW'(1);
        if (accept) begin
          pend   <= data_in;
          pend_v <= 1'b1;
        end
      end else begin
        // Word completes; pending word wins over a fresh input, keeping output gap-free.
        idx <= '0;
        if (pend_v) begin
          cur    <= pend;
          pend_v <= 1'b0;
        end else if (accept) begin
          cur <= data_in;
        end else begin
          cur_v <= 1'b0;
        end
      end
    end else begin
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      if (accept) begin
        cur   <= data_in;
        cur_v <= 1'b1;
        idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_demux_wide_narrow.sv
module tb_demux_wide_narrow;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int tests  = 0;
  int failed = 0;

  // Main instance: 32 -> 8, MSB first
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ready, m_valid_out, m_first, m_last;
  logic [7:0]  m_data_out;

  // LSB-first instance: 32 -> 8
  logic [31:0] l_data = '0;
  logic        l_valid = 1'b0;
  logic        l_ready, l_valid_out, l_first, l_last;
  logic [7:0]  l_data_out;

  // Non-power-of-2 instance: 24 -> 8, MSB first
  logic [23:0] o_data = '0;
  logic        o_valid = 1'b0;
  logic        o_ready, o_valid_out, o_first, o_last;
  logic [7:0]  o_data_out;

  demux_wide_narrow #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_main (
    .clk_4f(clk_4f), .reset(reset), .data_in(m_data), .valid_in(m_valid),
    .ready_out(m_ready), .data_out(m_data_out), .valid_out(m_valid_out),
    .first_out(m_first), .last_out(m_last)
  );

  demux_wide_narrow #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(l_data), .valid_in(l_valid),
    .ready_out(l_ready), .data_out(l_data_out), .valid_out(l_valid_out),
    .first_out(l_first), .last_out(l_last)
  );

  demux_wide_narrow #(.IN_W(24), .OUT_W(8), .MSB_FIRST(1'b1)) u_odd (
    .clk_4f(clk_4f), .reset(reset), .data_in(o_data), .valid_in(o_valid),
    .ready_out(o_ready), .data_out(o_data_out), .valid_out(o_valid_out),
    .first_out(o_first), .last_out(o_last)
  );

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e [4];
    e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    reset   = 1'b0;
    m_valid = 1'b1;
    m_data  = 32'hFFFF_FFFF;
    repeat (3) step();
    tests++; if (m_data_out !== 8'h00) begin failed++; $display("FAIL reset_data: got %h want 00", m_data_out); end
    tests++; if (m_valid_out !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", m_valid_out); end
    tests++; if (m_first !== 1'b0 || m_last !== 1'b0) begin failed++; $display("FAIL reset_first_last: got %b%b want 00", m_first, m_last); end
    tests++; if (m_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", m_ready); end
    tests++; if (l_valid_out !== 1'b0 || o_valid_out !== 1'b0) begin failed++; $display("FAIL reset_other_valid: got %b%b want 00", l_valid_out, o_valid_out); end
    reset  = 1'b1;
    m_data = 32'hA1B2_C3D4;
    step();
    m_valid = 1'b0;
    tests++; if (m_valid_out !== 1'b0) begin failed++; $display("FAIL reset_latency: valid_out %b want 0 on accept edge", m_valid_out); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (m_valid_out !== 1'b1 || m_data_out !== e[i]) begin failed++; $display("FAIL first_word[%0d]: got v=%b %h want v=1 %h", i, m_valid_out, m_data_out, e[i]); end
      tests++; if (m_first !== (i == 0) || m_last !== (i == 3)) begin failed++; $display("FAIL first_word_flags[%0d]: got %b%b want %b%b", i, m_first, m_last, i == 0, i == 3); end
    end
    step();
    tests++; if (m_valid_out !== 1'b0 || m_data_out !== 8'hD4) begin failed++; $display("FAIL first_word_idle: got v=%b %h want v=0 d4", m_valid_out, m_data_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [7:0]  e [12];
    int wi, bi;
    bit started, saw_nr, acc;
    w = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    wi = 0; bi = 0; started = 0; saw_nr = 0;
    for (int cyc = 0; cyc < 40 && bi < 12; cyc++) begin
      if (wi < 3) begin m_valid = 1'b1; m_data = w[wi]; end
      else m_valid = 1'b0;
      acc = m_valid && m_ready;
      if (!m_ready) saw_nr = 1;
      step();
      if (acc) wi++;
      if (m_valid_out) begin
        started = 1;
        tests++; if (m_data_out !== e[bi]) begin failed++; $display("FAIL b2b_data[%0d]: got %h want %h", bi, m_data_out, e[bi]); end
        tests++; if (m_first !== (bi % 4 == 0) || m_last !== (bi % 4 == 3)) begin failed++; $display("FAIL b2b_flags[%0d]: got %b%b want %b%b", bi, m_first, m_last, bi % 4 == 0, bi % 4 == 3); end
        bi++;
      end else if (started) begin
        tests++; failed++; $display("FAIL b2b_gap: valid_out 0 after %0d bytes, want 1", bi);
      end
    end
    m_valid = 1'b0;
    tests++; if (bi != 12) begin failed++; $display("FAIL b2b_count: got %0d bytes want 12", bi); end
    tests++; if (!saw_nr) begin failed++; $display("FAIL b2b_ready_drop: ready_out never 0, want 0 while pending full"); end
  endtask

  task automatic test_valid_drop();
    logic [7:0] e [4];
    e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    repeat (2) step();
    m_valid = 1'b1;
    m_data  = 32'hDEAD_BEEF;
    step();
    m_valid = 1'b0;
    m_data  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (m_valid_out !== 1'b1 || m_data_out !== e[i]) begin failed++; $display("FAIL drop_data[%0d]: got v=%b %h want v=1 %h", i, m_valid_out, m_data_out, e[i]); end
    end
    step();
    tests++; if (m_valid_out !== 1'b0 || m_data_out !== 8'hEF) begin failed++; $display("FAIL drop_idle: got v=%b %h want v=0 ef", m_valid_out, m_data_out); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] e [4];
    e = '{8'h04, 8'h03, 8'h02, 8'h01};
    l_valid = 1'b1;
    l_data  = 32'h0102_0304;
    step();
    l_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (l_valid_out !== 1'b1 || l_data_out !== e[i]) begin failed++; $display("FAIL lsb_data[%0d]: got v=%b %h want v=1 %h", i, l_valid_out, l_data_out, e[i]); end
      tests++; if (l_first !== (i == 0) || l_last !== (i == 3)) begin failed++; $display("FAIL lsb_flags[%0d]: got %b%b want %b%b", i, l_first, l_last, i == 0, i == 3); end
    end
    step();
    tests++; if (l_valid_out !== 1'b0) begin failed++; $display("FAIL lsb_idle: valid_out %b want 0", l_valid_out); end
  endtask

  task automatic test_non_pow2();
    logic [7:0] e [6];
    e = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
    o_valid = 1'b1;
    o_data  = 24'hABCDEF;
    step();
    o_data = 24'h123456;
    step();
    o_valid = 1'b0;
    tests++; if (o_ready !== 1'b0) begin failed++; $display("FAIL odd_ready: got %b want 0 with pending loaded", o_ready); end
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step();
      tests++; if (o_valid_out !== 1'b1 || o_data_out !== e[i]) begin failed++; $display("FAIL odd_data[%0d]: got v=%b %h want v=1 %h", i, o_valid_out, o_data_out, e[i]); end
      tests++; if (o_first !== (i % 3 == 0) || o_last !== (i % 3 == 2)) begin failed++; $display("FAIL odd_flags[%0d]: got %b%b want %b%b", i, o_first, o_last, i % 3 == 0, i % 3 == 2); end
    end
    step();
    tests++; if (o_valid_out !== 1'b0) begin failed++; $display("FAIL odd_idle: valid_out %b want 0", o_valid_out); end
  endtask

  task automatic test_reset_mid();
    repeat (2) step();
    m_valid = 1'b1;
    m_data  = 32'h1234_5678;
    step();
    m_data = 32'h9ABC_DEF0;
    step();
    m_valid = 1'b0;
    tests++; if (m_valid_out !== 1'b1 || m_data_out !== 8'h12 || m_first !== 1'b1) begin failed++; $display("FAIL mid_first_byte: got v=%b f=%b %h want v=1 f=1 12", m_valid_out, m_first, m_data_out); end
    tests++; if (m_ready !== 1'b0) begin failed++; $display("FAIL mid_pend_full: ready %b want 0", m_ready); end
    reset = 1'b0;
    step();
    tests++; if (m_ready !== 1'b1) begin failed++; $display("FAIL mid_ready: got %b want 1", m_ready); end
    tests++; if (m_valid_out !== 1'b0 || m_data_out !== 8'h00) begin failed++; $display("FAIL mid_cleared: got v=%b %h want v=0 00", m_valid_out, m_data_out); end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (m_valid_out !== 1'b0) begin failed++; $display("FAIL mid_no_output[%0d]: valid_out %b want 0", i, m_valid_out); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_drop();
    test_lsb_first();
    test_non_pow2();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/demux_wide_narrow.md
Name: demux_wide_narrow

Overview:
- Parametrised wide-to-narrow word serializer for the PCIe physical-layer byte path.
- Accepts IN_W-bit words on a valid/ready handshake and emits them as R = IN_W/OUT_W consecutive OUT_W-bit slices on clk_4f.
- Slice order is selectable at elaboration (MSB-first or LSB-first).
- A two-entry buffer (active word plus pending word) sustains gap-free output. A word in flight is never aborted or lost when valid_in drops.

Parameters:
- IN_W, 32, input word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output slice width.
- MSB_FIRST, 1, 1 = slice 0 is data_in[IN_W-1 -: OUT_W]; 0 = slice 0 is data_in[OUT_W-1:0].

Ports:
- clk_4f  input  1  serial-side clock.
- reset  input  1  synchronous, active-low.
- data_in  input  IN_W  word to serialize.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  OUT_W  current slice, registered.
- valid_out  output  1  data_out valid, registered.
- first_out  output  1  data_out is slice 0 of its word, registered.
- last_out  output  1  data_out is slice R-1 of its word, registered.

Behaviour:
- Reset and clock:
  - Reset is "reset, synchronous, active-low; clock clk_4f".
  - While reset==0 at a clk_4f edge, all of the following clear to 0: data_out, valid_out, first_out, last_out, cur_v, pend_v, idx.
  - Reset mid-word discards the active and pending words. No partial word is emitted after reset releases.
- Derived values:
  - R = IN_W/OUT_W, with R >= 2 required.
  - IDX_W = clog2(R).
- State:
  - cur: IN_W register; cur_v: valid flag; idx: IDX_W slice index.
  - pend: IN_W register; pend_v: valid flag.
- Handshake:
  - ready_out = !pend_v. It is combinational from state only, with no path from valid_in.
  - A word is accepted at an edge where valid_in & ready_out.
- Per edge when cur_v==1 (emit):
  - data_out <= slice(cur, idx); valid_out <= 1.
  - first_out <= (idx==0); last_out <= (idx==R-1).
  - If idx != R-1: idx <= idx+1.
  - If idx == R-1, the word completes and idx <= 0. Then, in priority order:
    - pend_v: cur <= pend; cur_v stays 1; pend_v <= 0.
    - else accept: cur <= data_in; cur_v stays 1.
    - else cur_v <= 0.
- Per edge when cur_v==0:
  - valid_out, first_out and last_out <= 0. data_out holds its last value.
  - An accept loads cur <= data_in, cur_v <= 1, idx <= 0.
- Accept while cur_v==1 and not on the last slice: pend <= data_in; pend_v <= 1.
- Latency: slice 0 appears on data_out one edge after the accepting edge.
- Throughput: one word per R cycles, with no bubble between words when the next word is available (in pend or on the input) at the last-slice edge.
- Boundary conditions:
  - valid_in deasserting mid-word does not stop the active word; all R slices are emitted.
  - Holding valid_in high with the same data while ready_out==0 is not an accept, so no duplication occurs.
  - idx wrap is exact at R-1, including for non-power-of-2 R (e.g. IN_W=24, OUT_W=8, R=3).

Decomposition:
- Package demux_pkg: function clog2, localparams R and IDX_W, and the elaboration check on IN_W % OUT_W == 0 and R >= 2.
- Sub-module slice_sel: purely combinational slice extraction from (word, idx, MSB_FIRST). It is reused by the future lane-striping block.

Test Plan:
- Reset: hold reset=0 for 3 edges with valid_in=1 → all outputs 0, ready_out=1. Release reset and drive 0xA1B2C3D4 → 0xA1, 0xB2, 0xC3, 0xD4 on consecutive edges; first_out on 0xA1, last_out on 0xD4.
- Back-to-back: drive 0x11223344, 0x55667788, 0x99AABBCC with valid_in held high and honouring ready_out → 12 contiguous valid bytes in order, no gap. ready_out drops to 0 while pend is full.
- valid_in drop mid-word: accept 0xDEADBEEF, deassert valid_in the next cycle → 0xDE, 0xAD, 0xBE, 0xEF still emitted, then valid_out=0 with data_out held at 0xEF.
- LSB-first: MSB_FIRST=0 with 0x01020304 → 0x04, 0x03, 0x02, 0x01.
- Non-power-of-2 width: IN_W=24 with 0xABCDEF → 0xAB, 0xCD, 0xEF, then idx returns to 0 and the next word's slice 0 follows immediately.
- Reset mid-operation: assert reset after 0x12 of 0x12345678 is emitted, with a pending word loaded → no further valid bytes; ready_out=1 after one edge.
